demux_reg_pair: RTL and testbench

- Registered 1-to-2 demultiplexer that collects two consecutive words from a single producer stream into two holding slots.
- The slot filled first is chosen by Selector.
- Presents the two slots as a validated pair to the consumer and holds them until the consumer acknowledges.
- Sits on the multicycle MIPS datapath between a single-word source (memory data / register read port) and stages needing two operands at once.

---
 rtl/demux_reg_pair_pkg.sv | 16 +
 rtl/demux_slot_register.sv | 38 +++
 rtl/demux_reg_pair.sv | 137 +++++++++++++
 tb/tb_demux_reg_pair.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_reg_pair_pkg.sv
// demux_reg_pair_pkg
//   Shared definitions for the two-word collecting demultiplexer:
//   FSM state encoding and the default datapath widths.
package demux_reg_pair_pkg;

    localparam int WORD_LENGTH_DEF = 32;
    localparam int COUNT_WIDTH_DEF = 8;
    localparam int NUM_SLOTS       = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        GOT_FIRST  = 2'b01,
        PAIR_READY = 2'b10
    } state_t;

endpackage

// File: rtl/demux_slot_register.sv
// demux_slot_register
//   One holding slot: a WORD_LENGTH data register plus a valid flag.
//   Ports:
//     clk, reset     - clock, asynchronous active-high reset
//     load           - capture data_in and set valid
//     clear          - drop valid (data is retained)
//     data_in        - word to capture
//     data_out       - registered word
//     valid          - slot holds a word of the current pair
module demux_slot_register
    import demux_reg_pair_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   clear,
    input  logic [WORD_LENGTH-1:0] data_in,
    output logic [WORD_LENGTH-1:0] data_out,
    output logic                   valid
);

    // load wins over clear: a retire-and-refill cycle clears the other
    // slot but this one takes the first word of the next pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            data_out <= data_in;
            valid    <= 1'b1;
        end else if (clear) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_reg_pair.sv
// demux_reg_pair
//   Registered 1-to-2 demultiplexer: collects two consecutive words from
//   one producer into two slots (first slot chosen by Selector), presents
//   them as a pair and holds them until Out_Ack.
//   Ports:
//     clk, reset              - clock, asynchronous active-high reset
//     Data_In, In_Valid       - producer word / valid
//     In_Ready                - combinational accept enable
//     Selector                - slot of the first word (sampled on first accept)
//     Flush                   - synchronous abort of the current pair
//     Out_Ack                 - consumer took the pair
//     Slot_Out_0/1, Valid_0/1 - slot registers and their valid flags
//     Pair_Valid              - both slots valid
//     Pair_Count              - acknowledged pairs, wraps
module demux_reg_pair
    import demux_reg_pair_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] Data_In,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic                   Selector,
    input  logic                   Flush,
    input  logic                   Out_Ack,
    output logic [WORD_LENGTH-1:0] Slot_Out_0,
    output logic [WORD_LENGTH-1:0] Slot_Out_1,
    output logic                   Valid_0,
    output logic                   Valid_1,
    output logic                   Pair_Valid,
    output logic [COUNT_WIDTH-1:0] Pair_Count
);

    state_t                                 state_q, state_d;
    logic                                   first_sel_q;
    logic                                   pair_valid_q;
    logic [COUNT_WIDTH-1:0]                 count_q;
    logic [NUM_SLOTS-1:0]                   load, clear;
    logic [NUM_SLOTS-1:0][WORD_LENGTH-1:0]  slot_data;
    logic [NUM_SLOTS-1:0]                   slot_valid;
    logic                                   accept;
    logic                                   retire;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       if (accept) state_d = GOT_FIRST;
                GOT_FIRST:  if (accept) state_d = PAIR_READY;
                // ack together with a new word starts the next pair at once
                PAIR_READY: if (Out_Ack) state_d = accept ? GOT_FIRST : IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // In PAIR_READY the ack bypasses into In_Ready so a new first word can
    // land in the retire cycle, giving one pair every two cycles.
    always_comb begin
        In_Ready = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE, GOT_FIRST: In_Ready = ~Flush;
                PAIR_READY:      In_Ready = Out_Ack & ~Flush;
                default:         In_Ready = 1'b0;
            endcase
        end
    end

    assign accept = In_Valid & In_Ready;
    assign retire = (state_q == PAIR_READY) & Out_Ack & ~Flush;

    // Slot steering. The second word always goes to the slot the first
    // word did not use; Selector only matters for a first word.
    always_comb begin
        load  = '0;
        clear = '0;
        if (Flush) begin
            clear = '1;
        end else begin
            if (retire) clear = '1;
            if (accept) begin
                if (state_q == GOT_FIRST) load[~first_sel_q] = 1'b1;
                else                      load[Selector]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_sel_q  <= 1'b0;
            pair_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            if (accept && state_q != GOT_FIRST) first_sel_q <= Selector;

            if (Flush)                                pair_valid_q <= 1'b0;
            else if (accept && state_q == GOT_FIRST)  pair_valid_q <= 1'b1;
            else if (retire)                          pair_valid_q <= 1'b0;

            if (retire) count_q <= count_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        demux_slot_register #(.WORD_LENGTH(WORD_LENGTH)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[i]),
            .clear    (clear[i]),
            .data_in  (Data_In),
            .data_out (slot_data[i]),
            .valid    (slot_valid[i])
        );
    end

    assign Slot_Out_0 = slot_data[0];
    assign Slot_Out_1 = slot_data[1];
    assign Valid_0    = slot_valid[0];
    assign Valid_1    = slot_valid[1];
    assign Pair_Valid = pair_valid_q;
    assign Pair_Count = count_q;

endmodule

// File: tb/tb_demux_reg_pair.sv
// tb_demux_reg_pair
//   Directed bench for demux_reg_pair: reset, pair collection in both slot
//   orders, stall and ack bypass, flush, counter wrap, async reset.
module tb_demux_reg_pair;

    logic        clk;
    logic        reset;
    logic [31:0] Data_In;
    logic        In_Valid;
    logic        In_Ready;
    logic        Selector;
    logic        Flush;
    logic        Out_Ack;
    logic [31:0] Slot_Out_0;
    logic [31:0] Slot_Out_1;
    logic        Valid_0;
    logic        Valid_1;
    logic        Pair_Valid;
    logic [7:0]  Pair_Count;

    int          tests;
    int          fails;
    logic [7:0]  exp_count;

    demux_reg_pair #(.WORD_LENGTH(32), .COUNT_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .Data_In    (Data_In),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Selector   (Selector),
        .Flush      (Flush),
        .Out_Ack    (Out_Ack),
        .Slot_Out_0 (Slot_Out_0),
        .Slot_Out_1 (Slot_Out_1),
        .Valid_0    (Valid_0),
        .Valid_1    (Valid_1),
        .Pair_Valid (Pair_Valid),
        .Pair_Count (Pair_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance past the next rising edge; registered outputs are stable
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; In_Valid = 1'b1; Data_In = 32'h0; Selector = 1'b0; Flush = 1'b0; Out_Ack = 1'b0;
        tick(); tick();
        tests++;
        if ({Slot_Out_0, Slot_Out_1, Valid_0, Valid_1, Pair_Valid, Pair_Count, In_Ready} !== '0) begin
            fails++;
            $display("FAIL reset_state: s0=%h s1=%h v=%b%b pv=%b cnt=%0d rdy=%b, want all 0",
                     Slot_Out_0, Slot_Out_1, Valid_0, Valid_1, Pair_Valid, Pair_Count, In_Ready);
        end
        In_Valid = 1'b0;
        reset = 1'b0;
        #1;
        tests++;
        if (In_Ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", In_Ready); end
    endtask

    task automatic test_basic_pair();
        In_Valid = 1'b1; Data_In = 32'h1111_1111; Selector = 1'b0;
        #1;
        tests++;
        if (In_Ready !== 1'b1) begin fails++; $display("FAIL basic_idle_ready: got %b want 1", In_Ready); end
        tick();
        tests++;
        if ({Valid_0, Valid_1, Pair_Valid} !== 3'b100 || Slot_Out_0 !== 32'h1111_1111) begin
            fails++; $display("FAIL basic_first: v0v1pv=%b s0=%h want 100 11111111", {Valid_0, Valid_1, Pair_Valid}, Slot_Out_0);
        end
        Data_In = 32'hAAAA_AAAA; Selector = 1'b1;
        tick();
        In_Valid = 1'b0;
        tests++;
        if ({Valid_0, Valid_1, Pair_Valid} !== 3'b111 || Slot_Out_0 !== 32'h1111_1111 || Slot_Out_1 !== 32'hAAAA_AAAA) begin
            fails++; $display("FAIL basic_pair: v=%b s0=%h s1=%h want 111 11111111 aaaaaaaa",
                              {Valid_0, Valid_1, Pair_Valid}, Slot_Out_0, Slot_Out_1);
        end
        Out_Ack = 1'b1;
        tick();
        Out_Ack = 1'b0;
        #1;
        tests++;
        if (Pair_Count !== 8'd1 || {Valid_0, Valid_1, Pair_Valid} !== 3'b000 || In_Ready !== 1'b1) begin
            fails++; $display("FAIL basic_ack: cnt=%0d v=%b rdy=%b want 1 000 1", Pair_Count, {Valid_0, Valid_1, Pair_Valid}, In_Ready);
        end
        // ack with nothing presented must not count
        Out_Ack = 1'b1;
        tick();
        Out_Ack = 1'b0;
        tests++;
        if (Pair_Count !== 8'd1 || {Valid_0, Valid_1, Pair_Valid} !== 3'b000) begin
            fails++; $display("FAIL idle_ack_ignored: cnt=%0d v=%b want 1 000", Pair_Count, {Valid_0, Valid_1, Pair_Valid});
        end
    endtask

    task automatic test_selector();
        In_Valid = 1'b1; Data_In = 32'h5; Selector = 1'b1;
        tick();
        tests++;
        if ({Valid_0, Valid_1, Pair_Valid} !== 3'b010 || Slot_Out_1 !== 32'h5) begin
            fails++; $display("FAIL sel_first: v=%b s1=%h want 010 5", {Valid_0, Valid_1, Pair_Valid}, Slot_Out_1);
        end
        Data_In = 32'h6; Selector = 1'b0;
        tick();
        In_Valid = 1'b0;
        tests++;
        if ({Valid_0, Valid_1, Pair_Valid} !== 3'b111 || Slot_Out_0 !== 32'h6 || Slot_Out_1 !== 32'h5) begin
            fails++; $display("FAIL sel_pair: v=%b s0=%h s1=%h want 111 6 5", {Valid_0, Valid_1, Pair_Valid}, Slot_Out_0, Slot_Out_1);
        end
    endtask

    task automatic test_stall();
        In_Valid = 1'b1; Data_In = 32'hDEAD_BEEF; Selector = 1'b1; Out_Ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (In_Ready !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d]: got %b want 0", i, In_Ready); end
            tick();
            tests++;
            if ({Valid_0, Valid_1, Pair_Valid} !== 3'b111 || Slot_Out_0 !== 32'h6 || Slot_Out_1 !== 32'h5) begin
                fails++; $display("FAIL stall_hold[%0d]: v=%b s0=%h s1=%h want 111 6 5", i, {Valid_0, Valid_1, Pair_Valid}, Slot_Out_0, Slot_Out_1);
            end
        end
        Out_Ack = 1'b1; Data_In = 32'h7; Selector = 1'b0;
        #1;
        tests++;
        if (In_Ready !== 1'b1) begin fails++; $display("FAIL bypass_ready: got %b want 1", In_Ready); end
        tick();
        Out_Ack = 1'b0; In_Valid = 1'b0;
        tests++;
        if (Pair_Count !== 8'd2 || Slot_Out_0 !== 32'h7 || Slot_Out_1 !== 32'h5 || {Valid_0, Valid_1, Pair_Valid} !== 3'b100) begin
            fails++; $display("FAIL bypass_refill: cnt=%0d s0=%h s1=%h v=%b want 2 7 5 100",
                              Pair_Count, Slot_Out_0, Slot_Out_1, {Valid_0, Valid_1, Pair_Valid});
        end
        In_Valid = 1'b1; Data_In = 32'h8; Selector = 1'b0;
        tick();
        In_Valid = 1'b0;
        tests++;
        if ({Valid_0, Valid_1, Pair_Valid} !== 3'b111 || Slot_Out_0 !== 32'h7 || Slot_Out_1 !== 32'h8) begin
            fails++; $display("FAIL bypass_second: v=%b s0=%h s1=%h want 111 7 8", {Valid_0, Valid_1, Pair_Valid}, Slot_Out_0, Slot_Out_1);
        end
        Out_Ack = 1'b1;
        tick();
        Out_Ack = 1'b0;
        tests++;
        if (Pair_Count !== 8'd3) begin fails++; $display("FAIL bypass_count: got %0d want 3", Pair_Count); end
    endtask

    task automatic test_flush();
        In_Valid = 1'b1; Data_In = 32'h9; Selector = 1'b0;
        tick();
        Flush = 1'b1; Data_In = 32'h10;
        #1;
        tests++;
        if (In_Ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b want 0", In_Ready); end
        tick();
        Flush = 1'b0; In_Valid = 1'b0;
        #1;
        tests++;
        if ({Valid_0, Valid_1, Pair_Valid} !== 3'b000 || Slot_Out_0 !== 32'h9 || Slot_Out_1 !== 32'h8 ||
            Pair_Count !== 8'd3 || In_Ready !== 1'b1) begin
            fails++; $display("FAIL flush_first: v=%b s0=%h s1=%h cnt=%0d rdy=%b want 000 9 8 3 1",
                              {Valid_0, Valid_1, Pair_Valid}, Slot_Out_0, Slot_Out_1, Pair_Count, In_Ready);
        end
        // Flush together with Out_Ack on a presented pair: no count
        In_Valid = 1'b1; Data_In = 32'h21;
        tick();
        Data_In = 32'h22;
        tick();
        In_Valid = 1'b0; Flush = 1'b1; Out_Ack = 1'b1;
        tick();
        Flush = 1'b0; Out_Ack = 1'b0;
        tests++;
        if ({Valid_0, Valid_1, Pair_Valid} !== 3'b000 || Pair_Count !== 8'd3 || Slot_Out_0 !== 32'h21 || Slot_Out_1 !== 32'h22) begin
            fails++; $display("FAIL flush_ack: v=%b cnt=%0d s0=%h s1=%h want 000 3 21 22",
                              {Valid_0, Valid_1, Pair_Valid}, Pair_Count, Slot_Out_0, Slot_Out_1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        exp_count = 8'd3;
        In_Valid = 1'b1; Selector = 1'b0;
        for (int k = 0; k < 512; k++) begin
            w = 32'hC000_0000 + k;
            Data_In = w;
            Out_Ack = (k >= 2 && (k % 2) == 0);
            #1;
            tests++;
            if (In_Ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, In_Ready); end
            tick();
            if (Out_Ack) exp_count = exp_count + 8'd1;
            tests++;
            if (Pair_Count !== exp_count) begin fails++; $display("FAIL b2b_count[%0d]: got %0d want %0d", k, Pair_Count, exp_count); end
            tests++;
            if ((k % 2) == 1) begin
                if ({Valid_0, Valid_1, Pair_Valid} !== 3'b111 || Slot_Out_0 !== w - 32'd1 || Slot_Out_1 !== w) begin
                    fails++; $display("FAIL b2b_pair[%0d]: v=%b s0=%h s1=%h want 111 %h %h",
                                      k, {Valid_0, Valid_1, Pair_Valid}, Slot_Out_0, Slot_Out_1, w - 32'd1, w);
                end
            end else begin
                if ({Valid_0, Valid_1, Pair_Valid} !== 3'b100 || Slot_Out_0 !== w) begin
                    fails++; $display("FAIL b2b_first[%0d]: v=%b s0=%h want 100 %h", k, {Valid_0, Valid_1, Pair_Valid}, Slot_Out_0, w);
                end
            end
        end
        In_Valid = 1'b0; Out_Ack = 1'b1;
        tick();
        Out_Ack = 1'b0;
        // 256 more pairs from 3 wraps back to 3
        tests++;
        if (Pair_Count !== 8'd3 || {Valid_0, Valid_1, Pair_Valid} !== 3'b000) begin
            fails++; $display("FAIL b2b_wrap: cnt=%0d v=%b want 3 000", Pair_Count, {Valid_0, Valid_1, Pair_Valid});
        end
    endtask

    task automatic test_async_reset();
        In_Valid = 1'b1; Data_In = 32'h12; Selector = 1'b1;
        tick();
        In_Valid = 1'b0;
        tests++;
        if ({Valid_0, Valid_1, Pair_Valid} !== 3'b010 || Slot_Out_1 !== 32'h12) begin
            fails++; $display("FAIL arst_setup: v=%b s1=%h want 010 12", {Valid_0, Valid_1, Pair_Valid}, Slot_Out_1);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({Slot_Out_0, Slot_Out_1, Valid_0, Valid_1, Pair_Valid, Pair_Count, In_Ready} !== '0) begin
            fails++; $display("FAIL arst_immediate: s0=%h s1=%h v=%b%b pv=%b cnt=%0d rdy=%b want all 0",
                              Slot_Out_0, Slot_Out_1, Valid_0, Valid_1, Pair_Valid, Pair_Count, In_Ready);
        end
        #3 reset = 1'b0;
        #1;
        tests++;
        if (In_Ready !== 1'b1 || {Valid_0, Valid_1, Pair_Valid} !== 3'b000) begin
            fails++; $display("FAIL arst_release: rdy=%b v=%b want 1 000", In_Ready, {Valid_0, Valid_1, Pair_Valid});
        end
        In_Valid = 1'b1; Data_In = 32'h31; Selector = 1'b0;
        tick();
        Data_In = 32'h32;
        tick();
        In_Valid = 1'b0;
        tests++;
        if ({Valid_0, Valid_1, Pair_Valid} !== 3'b111 || Slot_Out_0 !== 32'h31 || Slot_Out_1 !== 32'h32) begin
            fails++; $display("FAIL arst_fresh_pair: v=%b s0=%h s1=%h want 111 31 32", {Valid_0, Valid_1, Pair_Valid}, Slot_Out_0, Slot_Out_1);
        end
        Out_Ack = 1'b1;
        tick();
        Out_Ack = 1'b0;
        tests++;
        if (Pair_Count !== 8'd1) begin fails++; $display("FAIL arst_fresh_count: got %0d want 1", Pair_Count); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_count = 8'd0;
        test_reset();
        test_basic_pair();
        test_selector();
        test_stall();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
